// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Priority names mirror the per-cycle arbitration order, highest first.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned MD_CNT_W = 4;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1
   } md_state_e;

   typedef enum logic [2:0] {
      PRIO_EXT_STALL = 3'd0,
      PRIO_BRANCH    = 3'd1,
      PRIO_LOAD_USE  = 3'd2,
      PRIO_MD_WAIT   = 3'd3,
      PRIO_MD_START  = 3'd4,
      PRIO_NONE      = 3'd5
   } prio_e;

   // Load in EX whose destination feeds a source of the ID instruction.
   function automatic logic load_use(input logic             ex_mem_read,
                                     input logic [REG_W-1:0] ex_rd,
                                     input logic [REG_W-1:0] id_rs,
                                     input logic [REG_W-1:0] id_rt,
                                     input logic             id_uses_rt);
      return ex_mem_read && (ex_rd != REG_ZERO) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-controller signal bundle: hazard inputs in, hold/flush/status out.
interface pipe_hazard_ctrl_if #(parameter int unsigned PERF_W = 16);
   import pipe_ctrl_pkg::*;

   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic              id_uses_rt;
   logic              id_md_start;
   logic              ex_mem_read;
   logic [REG_W-1:0]  ex_rd;
   logic              ex_branch_taken;
   logic              ext_stall;

   logic              pc_hold;
   logic              hold_IFID;
   logic              flush_IFID;
   logic              hold_IDEX;
   logic              flush_IDEX;
   logic              md_busy;
   logic              md_done;
   logic              md_abort;
   logic [PERF_W-1:0] stall_cnt;
   logic [PERF_W-1:0] flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_md_start,
             ex_mem_read, ex_rd, ex_branch_taken, ext_stall,
      input  pc_hold, hold_IFID, flush_IFID, hold_IDEX, flush_IDEX,
             md_busy, md_done, md_abort, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_md_start,
             ex_mem_read, ex_rd, ex_branch_taken, ext_stall,
      output pc_hold, hold_IFID, flush_IFID, hold_IDEX, flush_IDEX,
             md_busy, md_done, md_abort, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: arbitrates stall, branch, load-use and mul/div
// wait into PC / IF/ID / ID/EX hold-flush controls, plus stall/flush perf counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 8,
   parameter int unsigned PERF_W     = 16
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave p
);

   md_state_e             r_state, w_next_state;
   logic [MD_CNT_W-1:0]   r_md_cnt, w_next_md_cnt;
   prio_e                 w_prio;
   logic                  w_lu;
   logic                  w_in_wait;
   logic                  w_pc_hold, w_hold_ifid, w_flush_ifid, w_hold_idex, w_flush_idex;
   logic                  w_md_done, w_md_abort;

   assign w_lu      = load_use(p.ex_mem_read, p.ex_rd, p.id_rs, p.id_rt, p.id_uses_rt);
   assign w_in_wait = (r_state == MD_WAIT);

   // Select the single winning hazard source for this cycle.
   always_comb begin
      w_prio = PRIO_NONE;
      if (p.ext_stall)
         w_prio = PRIO_EXT_STALL;
      else if (p.ex_branch_taken)
         w_prio = PRIO_BRANCH;
      else if (!w_in_wait && w_lu)
         w_prio = PRIO_LOAD_USE;
      else if (w_in_wait)
         w_prio = PRIO_MD_WAIT;
      else if (p.id_md_start)
         w_prio = PRIO_MD_START;
   end

   // Next state and Mealy controls; an unknown encoding falls back to RUN.
   always_comb begin
      w_next_state  = w_in_wait ? MD_WAIT : RUN;
      w_next_md_cnt = r_md_cnt;
      w_pc_hold     = 1'b0;
      w_hold_ifid   = 1'b0;
      w_flush_ifid  = 1'b0;
      w_hold_idex   = 1'b0;
      w_flush_idex  = 1'b0;
      w_md_done     = 1'b0;
      w_md_abort    = 1'b0;
      case (w_prio)
         PRIO_EXT_STALL: begin
            w_pc_hold   = 1'b1;
            w_hold_ifid = 1'b1;
            w_hold_idex = 1'b1;
         end
         PRIO_BRANCH: begin
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
            if (w_in_wait) begin
               w_md_abort    = 1'b1;
               w_next_state  = RUN;
               w_next_md_cnt = '0;
            end
         end
         PRIO_LOAD_USE: begin
            w_pc_hold    = 1'b1;
            w_hold_ifid  = 1'b1;
            w_flush_idex = 1'b1;
         end
         PRIO_MD_WAIT: begin
            w_pc_hold    = 1'b1;
            w_hold_ifid  = 1'b1;
            w_flush_idex = 1'b1;
            if (r_md_cnt <= MD_CNT_W'(1)) begin
               w_md_done     = 1'b1;
               w_next_state  = RUN;
               w_next_md_cnt = '0;
            end else begin
               w_next_md_cnt = r_md_cnt - MD_CNT_W'(1);
            end
         end
         PRIO_MD_START: begin
            w_next_state  = MD_WAIT;
            w_next_md_cnt = MD_CNT_W'(MD_LATENCY - 1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= RUN;
         r_md_cnt <= '0;
      end else begin
         r_state  <= w_next_state;
         r_md_cnt <= w_next_md_cnt;
      end
   end

   // Controls are forced low for the whole time reset is high, not just after an edge.
   assign p.pc_hold    = !reset && w_pc_hold;
   assign p.hold_IFID  = !reset && w_hold_ifid;
   assign p.flush_IFID = !reset && w_flush_ifid;
   assign p.hold_IDEX  = !reset && w_hold_idex;
   assign p.flush_IDEX = !reset && w_flush_idex;
   assign p.md_busy    = !reset && w_in_wait;
   assign p.md_done    = !reset && w_md_done;
   assign p.md_abort   = !reset && w_md_abort;

   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (p.pc_hold),
      .clr   (1'b0),
      .count (p.stall_cnt)
   );

   sat_counter #(.W(PERF_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (p.flush_IFID),
      .clr   (1'b0),
      .count (p.flush_cnt)
   );

   a_no_hold_and_flush: assert property (@(posedge clk) disable iff (reset)
      !(w_hold_ifid && w_flush_ifid) && !(w_hold_idex && w_flush_idex));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a
// remaining-wait-cycles reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned LAT = 8;
   localparam int unsigned PW  = 4;
   localparam int          SAT = 15;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.PERF_W(PW)) bus ();

   pipe_hazard_ctrl #(.MD_LATENCY(LAT), .PERF_W(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .p     (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: wait cycles still owed to mul/div (0 = not waiting).
   int m_md_left;
   int m_stall;
   int m_flush;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                    tag, obs, obs, exp, exp, $time);
   endtask

   function automatic int obs_ctrl();
      return int'({bus.pc_hold, bus.hold_IFID, bus.flush_IFID, bus.hold_IDEX,
                   bus.flush_IDEX, bus.md_busy, bus.md_done, bus.md_abort});
   endfunction

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic md_start, input logic mem_read, input logic [4:0] rd,
                        input logic br, input logic es);
      bus.id_rs           = rs;
      bus.id_rt           = rt;
      bus.id_uses_rt      = uses_rt;
      bus.id_md_start     = md_start;
      bus.ex_mem_read     = mem_read;
      bus.ex_rd           = rd;
      bus.ex_branch_taken = br;
      bus.ext_stall       = es;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic model_reset();
      m_md_left = 0;
      m_stall   = 0;
      m_flush   = 0;
   endtask

   // One clock: entered at posedge+1 with inputs driven; predicts, checks at
   // negedge, advances the model at the posedge and returns at posedge+1.
   task automatic cycle(input string tag);
      bit lu, ph, hi, fi, hx, fx, busy, done, abort;
      int nxt;
      lu = bus.ex_mem_read && (bus.ex_rd != 0) &&
           ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
      {ph, hi, fi, hx, fx, done, abort} = '0;
      busy = (m_md_left > 0);
      nxt  = m_md_left;
      if (bus.ext_stall) begin
         ph = 1; hi = 1; hx = 1;
      end else if (bus.ex_branch_taken) begin
         fi = 1; fx = 1;
         abort = busy;
         nxt = 0;
      end else if (busy || lu) begin
         ph = 1; hi = 1; fx = 1;
         if (busy) begin
            done = (m_md_left == 1);
            nxt  = m_md_left - 1;
         end
      end else if (bus.id_md_start) begin
         nxt = LAT - 1;
      end
      @(negedge clk);
      check_eq({tag, "_ctrl"}, obs_ctrl(),
               int'({ph, hi, fi, hx, fx, busy, done, abort}));
      check_eq({tag, "_stall_cnt"}, int'(bus.stall_cnt), m_stall);
      check_eq({tag, "_flush_cnt"}, int'(bus.flush_cnt), m_flush);
      @(posedge clk);
      m_md_left = nxt;
      if (ph && m_stall < SAT) m_stall++;
      if (fi && m_flush < SAT) m_flush++;
      #1;
   endtask

   // Synchronous-style reset pulse from posedge+1, returns at posedge+1.
   task automatic do_reset();
      idle();
      reset = 1'b1;
      #1;
      check_eq("rst_ctrl", obs_ctrl(), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_eq("rst_stall_cnt", int'(bus.stall_cnt), 0);
      check_eq("rst_flush_cnt", int'(bus.flush_cnt), 0);
   endtask

   initial begin
      model_reset();
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("por_ctrl", obs_ctrl(), 0);
      check_eq("por_stall_cnt", int'(bus.stall_cnt), 0);
      reset = 1'b0;

      // Load-use on rs for one cycle, then the producer leaves EX.
      drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      cycle("lu");
      idle();
      cycle("lu_clear");
      check_eq("lu_stall_total", int'(bus.stall_cnt), 1);
      // Load into r0 never stalls.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      cycle("lu_r0");
      // rt only matters when the instruction reads it.
      drive(5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      cycle("lu_rt_unused");
      drive(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      cycle("lu_rt_used");
      check_eq("lu_stall_total2", int'(bus.stall_cnt), 2);

      // Full mul/div wait: LAT-1 held cycles then done.
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle("md_issue");
      for (int i = 0; i < int'(LAT) - 1; i++) cycle("md_wait");
      idle();
      cycle("md_after");
      check_eq("md_stall_total", int'(bus.stall_cnt), int'(LAT) - 1);
      check_eq("md_busy_after", int'(bus.md_busy), 0);

      // Branch on the third wait cycle aborts the mul/div.
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle("ab_issue");
      idle();
      cycle("ab_wait1");
      cycle("ab_wait2");
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      cycle("ab_branch");
      idle();
      check_eq("ab_busy_next", int'(bus.md_busy), 0);
      check_eq("ab_flush_total", int'(bus.flush_cnt), 1);
      cycle("ab_after");

      // External stall mid-wait with a pending branch that fires afterwards.
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle("es_issue");
      idle();
      cycle("es_wait1");
      cycle("es_wait2");
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle("es_stalled");
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      cycle("es_branch");
      idle();
      cycle("es_after");
      check_eq("es_flush_total", int'(bus.flush_cnt), 1);

      // External stall freezes the countdown: wait still totals LAT-1 non-stalled cycles.
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle("fz_issue");
      idle();
      cycle("fz_wait");
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle("fz_stalled");
      idle();
      for (int i = 0; i < int'(LAT) - 2; i++) cycle("fz_wait_rest");
      check_eq("fz_busy_done", int'(bus.md_busy), 0);
      cycle("fz_after");

      // Saturation of the stall counter.
      do_reset();
      drive(5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle("sat");
      check_eq("sat_stall_total", int'(bus.stall_cnt), SAT);

      // Asynchronous reset in the middle of a mul/div wait.
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle("ar_issue");
      idle();
      cycle("ar_wait1");
      cycle("ar_wait2");
      #2;
      reset = 1'b1;
      #1;
      check_eq("ar_ctrl_now", obs_ctrl(), 0);
      check_eq("ar_stall_now", int'(bus.stall_cnt), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_eq("ar_busy_rel", int'(bus.md_busy), 0);
      cycle("ar_after");

      // Random traffic with small register indices to provoke collisions.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if (n % 250 == 249) do_reset();
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 99) < 25),
               1'($urandom_range(0, 99) < 30),
               5'($urandom_range(0, 3)),
               1'($urandom_range(0, 99) < 8),
               1'($urandom_range(0, 99) < 12));
         cycle("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
